// File: rtl/conv_seq_ctrl_if.sv
// Shared memory port between conv_seq_ctrl (master) and the memory (slave).
//   mem_addr_rd : read address (data returns one cycle later on mem_data_rd)
//   mem_data_rd : read data
//   mem_addr_wr : write address
//   mem_data_wr : write data
//   mem_wr_en   : write strobe
interface conv_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_addr_rd;
  logic [DATA_WIDTH-1:0] mem_data_rd;
  logic [ADDR_WIDTH-1:0] mem_addr_wr;
  logic [DATA_WIDTH-1:0] mem_data_wr;
  logic                  mem_wr_en;

  modport master (
    output mem_addr_rd, mem_addr_wr, mem_data_wr, mem_wr_en,
    input  mem_data_rd
  );

  modport slave (
    input  mem_addr_rd, mem_addr_wr, mem_data_wr, mem_wr_en,
    output mem_data_rd
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequences one convolution pass from a single start pulse:
// im2col -> weight load -> X load -> systolic run -> output store.
// Owns the shared memory port: passes im2col's port through during IM2COL,
// otherwise drives it from its own load/store engine.
// Optional build macro: CONV_RELU_EN (stored words with MSB set become 0).
// Ports:
//   clk, rst            clock, async active-high reset
//   i_start             one-cycle start pulse (only honoured when idle)
//   o_busy, o_done      pass in progress / one-cycle end-of-pass pulse
//   o_im2col_rst        im2col reset;  i_im2col_* im2col done + memory port
//   mem                 shared memory port (master side)
//   o_sa_rst            systolic reset; o_sa_x X row; o_sa_w weights
//   i_sa_y/valid/done   systolic result row, its valid, completion
module conv_seq_ctrl #(
  parameter int IMG_W       = 4,
  parameter int IMG_H       = 3,
  parameter int FILTER_SIZE = 3,
  parameter int FILTER_NUM  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 32'h1000,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 32'h2000,
  parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = 32'h3000,
  parameter int RST_CYC     = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_busy,
  output logic o_done,
  output logic o_im2col_rst,
  input  logic i_im2col_done,
  input  logic [ADDR_WIDTH-1:0] i_im2col_addr_rd,
  input  logic [ADDR_WIDTH-1:0] i_im2col_addr_wr,
  input  logic [DATA_WIDTH-1:0] i_im2col_data_wr,
  input  logic i_im2col_wr_en,
  conv_seq_ctrl_if.master mem,
  output logic o_sa_rst,
  output logic [DATA_WIDTH*FILTER_SIZE*FILTER_SIZE-1:0]            o_sa_x,
  output logic [DATA_WIDTH*FILTER_SIZE*FILTER_SIZE*FILTER_NUM-1:0] o_sa_w,
  input  logic [DATA_WIDTH*FILTER_NUM-1:0] i_sa_y,
  input  logic i_sa_valid,
  input  logic i_sa_done
);
  localparam int N  = FILTER_SIZE * FILTER_SIZE;
  localparam int K  = FILTER_NUM;
  localparam int M  = IMG_H * IMG_W;
  localparam int NK = N * K;
  localparam int MN = M * N;
  localparam int KM = K * M;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int CW = $clog2(MN + NK + KM + RST_CYC + 2);
  localparam int MW = (M > 1)  ? $clog2(M)  : 1;
  localparam int KW = (K > 1)  ? $clog2(K)  : 1;
  localparam int JW = (N > 1)  ? $clog2(N)  : 1;
  localparam int WW = (NK > 1) ? $clog2(NK) : 1;
  localparam int YW = $clog2(M + 1);

  localparam logic [CW-1:0] C_RSTM1 = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] C_NK    = CW'(NK);
  localparam logic [CW-1:0] C_MN    = CW'(MN);
  localparam logic [CW-1:0] C_M     = CW'(M);
  localparam logic [CW-1:0] C_MM1   = CW'(M - 1);
  localparam logic [KW-1:0] C_KM1   = KW'(K - 1);
  localparam logic [JW-1:0] C_NM1   = JW'(N - 1);
  localparam logic [YW-1:0] C_YM    = YW'(M);

  typedef enum logic [3:0] {
    S_IDLE, S_IM2C_RST, S_IM2COL, S_LOAD_W, S_LOAD_X,
    S_SA_RST, S_SA_RUN, S_STORE, S_FINISH
  } state_t;

  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;          // per-state cycle / index counter
  logic [KW-1:0] r_k;            // filter index while storing
  logic [MW-1:0] r_xm;           // xbuf row being filled
  logic [JW-1:0] r_xj;           // xbuf column being filled
  logic [YW-1:0] r_ycnt;         // result rows captured so far

  logic [NK-1:0][DW-1:0]         r_sa_w;
  logic [M-1:0][N-1:0][DW-1:0]   r_xbuf;
  logic [M-1:0][K-1:0][DW-1:0]   r_ybuf;

  logic [CW-1:0] w_cm1;
  logic [DW-1:0] w_y;
  logic [DW-1:0] w_wdata;

  assign o_sa_w = r_sa_w;
  assign w_cm1  = r_cnt - 1'b1;  // capture index: data lags its address by one cycle
  assign w_y    = r_ybuf[MW'(r_cnt)][r_k];

`ifdef CONV_RELU_EN
  assign w_wdata = w_y[DW-1] ? '0 : w_y;
`else
  assign w_wdata = w_y;
`endif

  // next state + outputs
  always_comb begin
    w_next          = r_state;
    o_busy          = (r_state != S_IDLE);
    o_done          = 1'b0;
    o_im2col_rst    = 1'b0;
    o_sa_rst        = 1'b1;
    o_sa_x          = '0;
    mem.mem_addr_rd = '0;
    mem.mem_addr_wr = '0;
    mem.mem_data_wr = '0;
    mem.mem_wr_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_im2col_rst = 1'b1;
        if (i_start) w_next = S_IM2C_RST;
      end
      S_IM2C_RST: begin
        o_im2col_rst = 1'b1;
        if (r_cnt == C_RSTM1) w_next = S_IM2COL;
      end
      S_IM2COL: begin
        mem.mem_addr_rd = i_im2col_addr_rd;
        mem.mem_addr_wr = i_im2col_addr_wr;
        mem.mem_data_wr = i_im2col_data_wr;
        mem.mem_wr_en   = i_im2col_wr_en;
        if (i_im2col_done) w_next = S_LOAD_W;
      end
      S_LOAD_W: begin
        if (r_cnt < C_NK) mem.mem_addr_rd = WEIGHT_BASE + AW'(r_cnt);
        if (r_cnt == C_NK) w_next = S_LOAD_X;
      end
      S_LOAD_X: begin
        if (r_cnt < C_MN) mem.mem_addr_rd = IM2COL_BASE + AW'(r_cnt);
        if (r_cnt == C_MN) w_next = S_SA_RST;
      end
      S_SA_RST: begin
        if (r_cnt == C_RSTM1) w_next = S_SA_RUN;
      end
      S_SA_RUN: begin
        o_sa_rst = 1'b0;
        if (r_cnt < C_M) o_sa_x = r_xbuf[MW'(r_cnt)];
        // a short result stream still ends the run; missing rows store 0
        if (i_sa_done) w_next = S_STORE;
      end
      S_STORE: begin
        o_sa_rst        = 1'b0;
        mem.mem_wr_en   = 1'b1;
        mem.mem_addr_wr = OUTPUT_BASE + AW'(r_k) * AW'(M) + AW'(r_cnt);
        mem.mem_data_wr = w_wdata;
        if (r_k == C_KM1 && r_cnt == C_MM1) w_next = S_FINISH;
      end
      S_FINISH: begin
        o_done       = 1'b1;
        o_im2col_rst = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_xm    <= '0;
      r_xj    <= '0;
      r_ycnt  <= '0;
      r_sa_w  <= '0;
      r_xbuf  <= '0;
      r_ybuf  <= '0;
    end else begin
      r_state <= w_next;

      if (w_next != r_state) r_cnt <= '0;
      else begin
        case (r_state)
          S_IM2C_RST, S_LOAD_W, S_LOAD_X, S_SA_RST: r_cnt <= r_cnt + 1'b1;
          S_SA_RUN: if (r_cnt != C_M) r_cnt <= r_cnt + 1'b1;  // stop once X rows exhausted
          S_STORE:  r_cnt <= (r_cnt == C_MM1) ? '0 : r_cnt + 1'b1;
          default:  r_cnt <= '0;
        endcase
      end

      if (r_state != S_STORE)  r_k <= '0;
      else if (r_cnt == C_MM1) r_k <= r_k + 1'b1;

      if (r_state == S_LOAD_W && r_cnt != '0)
        r_sa_w[WW'(w_cm1)] <= mem.mem_data_rd;

      if (r_state != S_LOAD_X) begin
        r_xm <= '0;
        r_xj <= '0;
      end else if (r_cnt != '0) begin
        r_xbuf[r_xm][r_xj] <= mem.mem_data_rd;
        if (r_xj == C_NM1) begin
          r_xj <= '0;
          r_xm <= r_xm + 1'b1;
        end else r_xj <= r_xj + 1'b1;
      end

      // results from a previous pass must not leak into unfilled rows
      if (r_state == S_IDLE) begin
        r_ycnt <= '0;
        r_ybuf <= '0;
      end else if (r_state == S_SA_RUN && i_sa_valid && r_ycnt < C_YM) begin
        r_ybuf[MW'(r_ycnt)] <= i_sa_y;
        r_ycnt <= r_ycnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: memory model, im2col stub and a
// behavioural systolic stub; expected outputs are computed as plain dot
// products over the bench's own memory image.
module tb_conv_seq_ctrl;
  localparam int N = 9, K = 5, M = 12, DW = 32, AW = 32;
  localparam logic [31:0] WB = 32'h1000, IB = 32'h2000, OB = 32'h3000;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic start = 1'b0, busy, done, im2col_rst;
  logic im2col_done = 1'b0, i2c_wen = 1'b0;
  logic [31:0] i2c_ard = '0, i2c_awr = '0, i2c_dwr = '0;
  logic sa_rst;
  logic [DW*N-1:0]   sa_x;
  logic [DW*N*K-1:0] sa_w;
  logic [DW*K-1:0]   sa_y = '0;
  logic sa_valid = 1'b0, sa_done = 1'b0;

  conv_seq_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif();

  conv_seq_ctrl dut (
    .clk(clk), .rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
    .o_im2col_rst(im2col_rst), .i_im2col_done(im2col_done),
    .i_im2col_addr_rd(i2c_ard), .i_im2col_addr_wr(i2c_awr),
    .i_im2col_data_wr(i2c_dwr), .i_im2col_wr_en(i2c_wen),
    .mem(mif.master), .o_sa_rst(sa_rst), .o_sa_x(sa_x), .o_sa_w(sa_w),
    .i_sa_y(sa_y), .i_sa_valid(sa_valid), .i_sa_done(sa_done)
  );

  int total = 0, bad = 0;
  logic [31:0] mem  [0:16383];
  logic [31:0] outm [0:63];
  logic [31:0] rlog [0:255];
  logic [31:0] expo [0:63];
  int nwr = 0, nrd = 0, ndone = 0, nother = 0;
  logic clr = 1'b0;

  function automatic logic [13:0] ma(input logic [31:0] a);
    return a[13:0];
  endfunction

  // memory: synchronous read, one-cycle latency
  always @(posedge clk) mif.mem_data_rd <= mem[ma(mif.mem_addr_rd)];

  // activity recorder: output writes, load reads, done pulses
  always @(posedge clk) begin
    if (clr) begin
      nwr <= 0; nrd <= 0; ndone <= 0; nother <= 0;
      for (int i = 0; i < 64; i++) outm[i] <= 32'hDEADBEEF;
    end else begin
      if (mif.mem_wr_en) begin
        if (mif.mem_addr_wr >= OB && mif.mem_addr_wr < OB + 32'd60) begin
          outm[ma(mif.mem_addr_wr - OB)] <= mif.mem_data_wr;
          nwr <= nwr + 1;
        end else nother <= nother + 1;
      end
      if (mif.mem_addr_rd >= WB && mif.mem_addr_rd < OB) begin
        if (nrd < 256) rlog[nrd] <= mif.mem_addr_rd;
        nrd <= nrd + 1;
      end
      if (done) ndone <= ndone + 1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [1439:0] obs, input logic [1439:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef CONV_RELU_EN
    return v[31] ? 32'd0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] wv(input int k, input int j);
    return mem[ma(WB + 32'(k*N + j))];
  endfunction

  function automatic logic [31:0] xv(input int m, input int j);
    return mem[ma(IB + 32'(m*N + j))];
  endfunction

  // 0: w=1,x=2   1: w=i+1, x=m*16+j   2: random small signed   3: w=-1,x=2
  task automatic load(input int mode);
    for (int i = 0; i < N*K; i++)
      case (mode)
        0: mem[ma(WB + 32'(i))] = 32'd1;
        1: mem[ma(WB + 32'(i))] = 32'(i + 1);
        2: mem[ma(WB + 32'(i))] = 32'($urandom_range(0, 15)) - 32'd8;
        default: mem[ma(WB + 32'(i))] = 32'hFFFF_FFFF;
      endcase
    for (int m = 0; m < M; m++)
      for (int j = 0; j < N; j++)
        case (mode)
          1: mem[ma(IB + 32'(m*N + j))] = 32'(m*16 + j);
          2: mem[ma(IB + 32'(m*N + j))] = 32'($urandom_range(0, 15)) - 32'd8;
          default: mem[ma(IB + 32'(m*N + j))] = 32'd2;
        endcase
  endtask

  task automatic stub_im2col(input bit pt_write, input string nm);
    int n = 0;
    while (im2col_rst && n < 50) begin tick(); n++; end
    chk({nm, ":rstcyc"}, n, 5);
    if (pt_write) begin
      i2c_wen = 1'b1; i2c_awr = 32'h0F00; i2c_dwr = $urandom; i2c_ard = 32'h0ABC;
      #1;
      chk({nm, ":pt_wen"}, mif.mem_wr_en, 1);
      chk({nm, ":pt_awr"}, mif.mem_addr_wr, 32'h0F00);
      chk({nm, ":pt_dwr"}, mif.mem_data_wr, i2c_dwr);
      chk({nm, ":pt_ard"}, mif.mem_addr_rd, 32'h0ABC);
    end
    tick();
    i2c_wen = 1'b0; i2c_ard = '0;
    tick(); tick();
    im2col_done = 1'b1;
    tick();
    im2col_done = 1'b0;
  endtask

  task automatic run_pass(input int nrows, input bit mid_start, input bit pt_write, input string nm);
    int n, nerr;
    logic [DW*N-1:0] xs [M];
    logic [DW*N-1:0] xe;
    logic [1439:0] we;
    logic [31:0] acc, ea;
    for (int k = 0; k < K; k++)
      for (int m = 0; m < M; m++) begin
        acc = '0;
        for (int j = 0; j < N; j++) acc += xv(m, j) * wv(k, j);
        expo[k*M + m] = (m < nrows) ? relu(acc) : 32'd0;
      end

    clr = 1'b1; tick(); clr = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk({nm, ":busy"}, busy, 1);
    stub_im2col(pt_write, nm);

    n = 0;
    while (sa_rst && n < 400) begin tick(); n++; end
    chk({nm, ":loadcyc"}, n, 160);
    if (mid_start) start = 1'b1;

    we = '0;
    for (int i = 0; i < N*K; i++) we[i*32 +: 32] = mem[ma(WB + 32'(i))];
    chk({nm, ":sa_w"}, sa_w, we);
    chk({nm, ":rdcnt"}, nrd, 153);
    nerr = 0;
    for (int i = 0; i < 153; i++) begin
      ea = (i < 45) ? WB + 32'(i) : IB + 32'(i - 45);
      if (rlog[i] !== ea) nerr++;
    end
    chk({nm, ":rdseq"}, nerr, 0);

    for (int m = 0; m < M; m++) begin
      for (int j = 0; j < N; j++) xe[j*32 +: 32] = xv(m, j);
      chk($sformatf("%s:sa_x%0d", nm, m), sa_x, xe);
      xs[m] = sa_x;
      tick();
      start = 1'b0;
    end
    chk({nm, ":sa_x_end"}, sa_x, 0);
    chk({nm, ":busy_run"}, busy, 1);

    for (int m = 0; m < nrows; m++) begin
      for (int k = 0; k < K; k++) begin
        acc = '0;
        for (int j = 0; j < N; j++) acc += xs[m][j*32 +: 32] * wv(k, j);
        sa_y[k*32 +: 32] = acc;
      end
      sa_valid = 1'b1;
      tick();
    end
    if (nrows == M) begin
      sa_y = {K{32'hBADC0DE5}};  // surplus row must be ignored
      sa_valid = 1'b1;
      tick();
    end
    sa_valid = 1'b0; sa_done = 1'b1;
    tick();
    sa_done = 1'b0;

    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    chk({nm, ":storecyc"}, n, 60);
    chk({nm, ":fin_i2c_rst"}, im2col_rst, 1);
    chk({nm, ":fin_sa_rst"}, sa_rst, 1);
    tick();
    chk({nm, ":done_low"}, done, 0);
    chk({nm, ":idle"}, busy, 0);
    chk({nm, ":ndone"}, ndone, 1);
    chk({nm, ":nwr"}, nwr, 60);
    chk({nm, ":nother"}, nother, 32'(pt_write));
    for (int i = 0; i < K*M; i++)
      chk($sformatf("%s:out%0d", nm, i), outm[i], expo[i]);
  endtask

  task automatic abort_in_load_x();
    int n = 0;
    clr = 1'b1; tick(); clr = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    stub_im2col(1'b0, "abort");
    while (mif.mem_addr_rd !== IB + 32'd5 && n < 300) begin tick(); n++; end
    chk("abort:reach_load_x", 32'(n < 300), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort:busy", busy, 0);
    chk("abort:i2c_rst", im2col_rst, 1);
    chk("abort:sa_rst", sa_rst, 1);
    chk("abort:addr_rd", mif.mem_addr_rd, 0);
    #2 rst = 1'b0;
    tick();
  endtask

  initial begin
    #12;
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:i2c_rst", im2col_rst, 1);
    chk("rst:sa_rst", sa_rst, 1);
    chk("rst:sa_x", sa_x, 0);
    chk("rst:sa_w", sa_w, 0);
    chk("rst:wr_en", mif.mem_wr_en, 0);
    chk("rst:addr_rd", mif.mem_addr_rd, 0);
    chk("rst:addr_wr", mif.mem_addr_wr, 0);
    rst = 1'b0;
    tick();

    load(0); run_pass(M, 1'b0, 1'b1, "A");
    load(1); run_pass(M, 1'b0, 1'b0, "C");
    load(2); run_pass(M, 1'b1, 1'b0, "B");
    abort_in_load_x();
    load(2); run_pass(M, 1'b0, 1'b0, "E");
    load(2); run_pass(10, 1'b0, 1'b0, "D");
    load(3); run_pass(M, 1'b0, 1'b0, "F");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
